// File: rtl/tex_mem_rsp_gather_if.sv
// tex_mem_rsp_gather_if: bundles the dcache response channel (rsp_*) and the
// assembled texel-quad channel toward the sampler (out_*), plus the drop pulse.
// The slave modport is the gatherer's view; master is the surrounding logic.
interface tex_mem_rsp_gather_if #(
    parameter int NUM_REQS      = 4,
    parameter int WORD_SIZE     = 4,
    parameter int NUM_TEXELS    = 4,
    parameter int REQ_TAG_WIDTH = 8
);
    localparam int WORD_WIDTH = 8 * WORD_SIZE;
    localparam int TW         = $clog2(NUM_TEXELS);
    localparam int TAG_WIDTH  = REQ_TAG_WIDTH + 2 * TW;

    logic                                        rsp_valid;
    logic [NUM_REQS-1:0]                         rsp_tmask;
    logic [NUM_REQS*WORD_WIDTH-1:0]              rsp_data;
    logic [TAG_WIDTH-1:0]                        rsp_tag;
    logic                                        rsp_ready;

    logic                                        out_valid;
    logic [NUM_REQS-1:0]                         out_tmask;
    logic [NUM_TEXELS*NUM_REQS*WORD_WIDTH-1:0]   out_data;
    logic [REQ_TAG_WIDTH-1:0]                    out_tag;
    logic                                        out_ready;

    logic                                        err;

    modport slave (
        input  rsp_valid, rsp_tmask, rsp_data, rsp_tag,
        output rsp_ready,
        output out_valid, out_tmask, out_data, out_tag,
        input  out_ready,
        output err
    );

    modport master (
        output rsp_valid, rsp_tmask, rsp_data, rsp_tag,
        input  rsp_ready,
        input  out_valid, out_tmask, out_data, out_tag,
        output out_ready,
        input  err
    );
endinterface

// File: rtl/tex_mem_rsp_gather.sv
// tex_mem_rsp_gather: gathers the 1..NUM_TEXELS per-texel dcache responses of
// one texture request (arriving in any order) into a single texel-quad beat.
// Incoming tag layout is {req_tag, cnt_m1, texel_idx}. Responses that do not
// belong to the request being collected are consumed and flagged on err.
// Optional feature macro: TEX_RSP_GATHER_PERF_EN adds perf_rsp_count and
// perf_stall_cycles counters as extra output ports.
module tex_mem_rsp_gather #(
    parameter int NUM_REQS      = 4,
    parameter int WORD_SIZE     = 4,
    parameter int NUM_TEXELS    = 4,
    parameter int REQ_TAG_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    tex_mem_rsp_gather_if.slave      bus
`ifdef TEX_RSP_GATHER_PERF_EN
    ,
    output logic [31:0]              perf_rsp_count,
    output logic [31:0]              perf_stall_cycles
`endif
);
    localparam int WORD_WIDTH = 8 * WORD_SIZE;
    localparam int TW         = $clog2(NUM_TEXELS);
    localparam int TAG_WIDTH  = REQ_TAG_WIDTH + 2 * TW;

    typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

    state_t                                     state, state_n;
    logic [NUM_TEXELS-1:0]                      rcv_mask, rcv_mask_n;
    logic [TW-1:0]                              cnt_m1;
    logic [REQ_TAG_WIDTH-1:0]                   out_tag_q;
    logic [NUM_REQS-1:0]                        out_tmask_q;
    logic [NUM_TEXELS*NUM_REQS*WORD_WIDTH-1:0]  out_data_q;
    logic                                       err_q;

    logic                                       acc, wr_en, start, drop;
    logic [REQ_TAG_WIDTH-1:0]                   in_tag;
    logic [TW-1:0]                              in_cnt, in_idx;
    logic [NUM_TEXELS-1:0]                      idx_bit;

    // True when every texel slot 0..cnt has been received.
    function automatic logic covered(input logic [NUM_TEXELS-1:0] m,
                                     input logic [TW-1:0] cnt);
        logic ok;
        ok = 1'b1;
        for (int t = 0; t < NUM_TEXELS; t++) begin
            if (TW'(t) <= cnt && !m[t]) ok = 1'b0;
        end
        return ok;
    endfunction

    assign in_tag  = bus.rsp_tag[TAG_WIDTH-1 -: REQ_TAG_WIDTH];
    assign in_cnt  = bus.rsp_tag[2*TW-1 -: TW];
    assign in_idx  = bus.rsp_tag[TW-1:0];
    assign idx_bit = NUM_TEXELS'(1) << in_idx;

    // Handshakes come straight from state so out_ready never reaches rsp_ready.
    assign bus.rsp_ready = (state != FULL);
    assign bus.out_valid = (state == FULL);
    assign acc           = bus.rsp_valid & bus.rsp_ready;

    assign bus.out_tag   = out_tag_q;
    assign bus.out_tmask = out_tmask_q;
    assign bus.out_data  = out_data_q;
    assign bus.err       = err_q;

    // Next-state, accept/drop classification and receive-mask update.
    always_comb begin
        state_n    = state;
        rcv_mask_n = rcv_mask;
        wr_en      = 1'b0;
        start      = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (acc) begin
                    if (in_idx > in_cnt) begin
                        drop = 1'b1;
                    end else begin
                        wr_en      = 1'b1;
                        start      = 1'b1;
                        rcv_mask_n = idx_bit;
                        state_n    = (in_cnt == '0) ? FULL : COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (acc) begin
                    if (in_tag != out_tag_q || rcv_mask[in_idx] || in_idx > cnt_m1) begin
                        drop = 1'b1;
                    end else begin
                        wr_en      = 1'b1;
                        rcv_mask_n = rcv_mask | idx_bit;
                        if (covered(rcv_mask | idx_bit, cnt_m1)) state_n = FULL;
                    end
                end
            end
            FULL: begin
                if (bus.out_ready) begin
                    state_n    = IDLE;
                    rcv_mask_n = '0;
                end
            end
            default: begin
                state_n    = IDLE;
                rcv_mask_n = '0;
            end
        endcase
    end

    // State and receive-mask registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rcv_mask <= '0;
        end else begin
            state    <= state_n;
            rcv_mask <= rcv_mask_n;
        end
    end

    // Quad assembly: first texel clears the buffer, later ones merge by lane mask.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_tag_q   <= '0;
            cnt_m1      <= '0;
            out_tmask_q <= '0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= drop;
            if (start) begin
                out_tag_q <= in_tag;
                cnt_m1    <= in_cnt;
            end
            if (wr_en) begin
                out_tmask_q <= start ? bus.rsp_tmask : (out_tmask_q | bus.rsp_tmask);
                for (int t = 0; t < NUM_TEXELS; t++) begin
                    for (int l = 0; l < NUM_REQS; l++) begin
                        if (TW'(t) == in_idx && bus.rsp_tmask[l]) begin
                            out_data_q[(t*NUM_REQS+l)*WORD_WIDTH +: WORD_WIDTH] <=
                                bus.rsp_data[l*WORD_WIDTH +: WORD_WIDTH];
                        end else if (start) begin
                            out_data_q[(t*NUM_REQS+l)*WORD_WIDTH +: WORD_WIDTH] <= '0;
                        end
                    end
                end
            end
        end
    end

`ifdef TEX_RSP_GATHER_PERF_EN
    // Free-running accept and output-stall counters; they wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_rsp_count    <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (acc) perf_rsp_count <= perf_rsp_count + 32'd1;
            if (bus.out_valid && !bus.out_ready) perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule
